frame_pattern_tx: RTL

- Transmit side of the fval/lval/dval/pix_data video interface: generates complete 8-bit monochrome frames carrying a selectable test pattern.
- Drives the frame grabber in loopback benches, and any downstream video sink in the frame_generator design.
- Produces line/frame timing with configurable blanking and optional intra-line dval gaps.

---
 rtl/frame_pattern_if.sv | 12 +
 rtl/frame_pattern_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/frame_pattern_if.sv
// Video transmit bundle: frame/line/data valids, 8-bit pixel and end-of-frame pulse.
// The generator drives it through the master modport; sinks use the slave modport.
interface frame_pattern_if;
  logic       fval;
  logic       lval;
  logic       dval;
  logic [7:0] pix_data;
  logic       frame_done;

  modport master (output fval, output lval, output dval, output pix_data, output frame_done);
  modport slave  (input  fval, input  lval, input  dval, input  pix_data, input  frame_done);
endinterface

// File: rtl/frame_pattern_tx.sv
// Test-pattern frame generator for the fval/lval/dval video interface.
// Outputs are registered from the next-state values, so state_q always matches what is on the bus.
module frame_pattern_tx #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int FV_SETUP = 4,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 32,
  parameter int DVAL_GAP = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2:0]      sel,
  frame_pattern_if.master vid
);

  localparam int          DATA_W     = 8;
  localparam logic [11:0] X_LAST     = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST     = 12'(HEIGHT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(FV_SETUP - 1);
  localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);
  localparam logic [15:0] RUN_LAST   = 16'(DVAL_GAP - 1);
  localparam bit          GAP_EN     = (DVAL_GAP > 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FSETUP = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic [15:0]         run_q, run_d;
  logic [15:0]         blank_q, blank_d;
  logic                in_gap_q, in_gap_d;
  logic [2:0]          sel_q, sel_d;
  logic                fval_q, fval_d;
  logic                lval_q, lval_d;
  logic                dval_q, dval_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   pix_q, pix_d;

  function automatic logic [DATA_W-1:0] pattern(input logic [2:0] s,
                                                input logic [11:0] x,
                                                input logic [11:0] y);
    logic [7:0] diag;
    diag = x[7:0] + y[7:0];
    case (s)
      3'b000:  return x[4] ? 8'hFF : 8'h00;
      3'b001:  return y[4] ? 8'hFF : 8'h00;
      3'b010:  return x[7:0];
      3'b011:  return (x[5] ^ y[5]) ? 8'hFF : 8'h00;
      3'b110:  return {x[6] ^ y[6], x[5] ^ y[5], 6'b0};
      3'b111:  return diag;
      default: return 8'h00;
    endcase
  endfunction

  // blank_q counts cycles spent in FSETUP/HBLANK/VBLANK; run_q counts pixels since the last gap.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    run_d    = run_q;
    blank_d  = blank_q;
    in_gap_d = 1'b0;
    sel_d    = sel_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FSETUP;
          sel_d   = sel;
          blank_d = '0;
        end
      end
      FSETUP: begin
        if (blank_q == SETUP_LAST) begin
          state_d = LINE;
          blank_d = '0;
          x_d     = '0;
          run_d   = '0;
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      LINE: begin
        if (in_gap_q) begin
          in_gap_d = 1'b0;
        end else if (x_q == X_LAST) begin
          state_d = HBLANK;
          x_d     = '0;
          blank_d = '0;
        end else begin
          x_d = x_q + 12'd1;
          if (GAP_EN && (run_q == RUN_LAST)) begin
            in_gap_d = 1'b1;
            run_d    = '0;
          end else begin
            run_d = run_q + 16'd1;
          end
        end
      end
      HBLANK: begin
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          if (y_q == Y_LAST) begin
            state_d = VBLANK;
            y_d     = '0;
          end else begin
            state_d = LINE;
            y_d     = y_q + 12'd1;
            run_d   = '0;
          end
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      VBLANK: begin
        if (blank_q == VB_LAST) begin
          blank_d = '0;
          if (en) begin
            state_d = FSETUP;
            sel_d   = sel;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus values for the coming cycle follow directly from the next state.
  always_comb begin
    fval_d       = (state_d == FSETUP) || (state_d == LINE) || (state_d == HBLANK);
    lval_d       = (state_d == LINE);
    dval_d       = (state_d == LINE) && !in_gap_d;
    pix_d        = dval_d ? pattern(sel_d, x_d, y_d) : 8'h00;
    frame_done_d = (state_d == VBLANK) && (state_q != VBLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      run_q        <= '0;
      blank_q      <= '0;
      in_gap_q     <= 1'b0;
      sel_q        <= '0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      dval_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      run_q        <= run_d;
      blank_q      <= blank_d;
      in_gap_q     <= in_gap_d;
      sel_q        <= sel_d;
      fval_q       <= fval_d;
      lval_q       <= lval_d;
      dval_q       <= dval_d;
      frame_done_q <= frame_done_d;
      pix_q        <= pix_d;
    end
  end

  assign vid.fval       = fval_q;
  assign vid.lval       = lval_q;
  assign vid.dval       = dval_q;
  assign vid.pix_data   = pix_q;
  assign vid.frame_done = frame_done_q;

endmodule
